// File: rtl/gcd_pkg.sv
// Shared types and helpers for the gcd scheduler slice: FSM state encoding,
// default datapath width and the id-width helper.
package gcd_pkg;

    localparam int GCD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Bits needed to index n items (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gcd_rr_arb.sv
// Rotating-priority arbiter: grants the first requester at or after ptr,
// scanning upward with wrap-around. Purely combinational.
module gcd_rr_arb
    import gcd_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [clog2(NREQ)-1:0]  ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [clog2(NREQ)-1:0]  gnt_idx,
    output logic                    gnt_any
);

    localparam int IDW = clog2(NREQ);

    always_comb begin : scan
        int             idx;
        logic [IDW-1:0] sel;
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            sel = IDW'(idx);
            if (!gnt_any && req[sel]) begin
                gnt_any  = 1'b1;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/gcd_sched.sv
// Shares one gcd engine among NREQ requesters: round-robin accept, local
// zero-operand bypass, engine start/done sequencing and a tagged response.
module gcd_sched
    import gcd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = GCD_W,
    parameter int CW   = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*W-1:0]       req_opa,
    input  logic [NREQ*W-1:0]       req_opb,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    output logic [clog2(NREQ)-1:0]  rsp_id,
    output logic [W-1:0]            rsp_result,
    output logic [CW-1:0]           rsp_cycles,
    input  logic                    rsp_ready,
    output logic [W-1:0]            eng_opa,
    output logic [W-1:0]            eng_opb,
    output logic                    eng_start,
    input  logic [W-1:0]            eng_result,
    input  logic                    eng_done
);

    localparam int IDW = clog2(NREQ);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [W-1:0]    opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d, cyc_q, cyc_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    logic [W-1:0]    gnt_opa, gnt_opb;
    logic [CW-1:0]   cnt_inc;

    gcd_rr_arb #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign gnt_opa = req_opa[int'(gnt_idx)*W +: W];
    assign gnt_opb = req_opb[int'(gnt_idx)*W +: W];
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        cyc_d     = cyc_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        eng_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    req_ready = gnt;
                    opa_d     = gnt_opa;
                    opb_d     = gnt_opb;
                    id_d      = gnt_idx;
                    ptr_d     = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
                    // A zero operand makes the answer the other operand (0 for 0,0).
                    if (gnt_opa == '0 || gnt_opb == '0) begin
                        res_d   = (gnt_opb == '0) ? gnt_opa : gnt_opb;
                        cyc_d   = '0;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                eng_start = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_inc;
                // The engine cleared done when it sampled start, so done here is ours.
                if (eng_done) begin
                    res_d   = eng_result;
                    cyc_d   = cnt_inc;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
        end
    end

    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_cycles = cyc_q;
    assign eng_opa    = opa_q;
    assign eng_opb    = opb_q;

endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched with a subtractive gcd engine model.
module tb_gcd_sched;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int CW   = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_opa, req_opb;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_result;
    logic [CW-1:0]     rsp_cycles;
    logic              rsp_ready;
    logic [W-1:0]      eng_opa, eng_opb;
    logic              eng_start;
    logic [W-1:0]      eng_result;
    logic              eng_done;

    int total = 0;
    int bad   = 0;

    gcd_sched #(.NREQ(NREQ), .W(W), .CW(CW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_opa    (req_opa),
        .req_opb    (req_opb),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_cycles (rsp_cycles),
        .rsp_ready  (rsp_ready),
        .eng_opa    (eng_opa),
        .eng_opb    (eng_opb),
        .eng_start  (eng_start),
        .eng_result (eng_result),
        .eng_done   (eng_done)
    );

    always #5 clk = ~clk;

    // Engine model: loads on start, clears done, subtracts until equal.
    logic [W-1:0] e_a, e_b;
    logic         e_busy, e_done;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e_a <= '0; e_b <= '0; e_busy <= 1'b0; e_done <= 1'b0;
        end else if (eng_start) begin
            e_a <= eng_opa; e_b <= eng_opb; e_busy <= 1'b1; e_done <= 1'b0;
        end else if (e_busy) begin
            if (e_a == e_b) begin
                e_done <= 1'b1; e_busy <= 1'b0;
            end else if (e_a > e_b) begin
                e_a <= e_a - e_b;
            end else begin
                e_b <= e_b - e_a;
            end
        end
    end
    assign eng_result = e_a;
    assign eng_done   = e_done;

    // Start-pulse monitor and count of cycles between start and response.
    int   start_cnt = 0;
    int   dbl_start = 0;
    int   wc        = 0;
    int   last_wait = 0;
    logic counting  = 1'b0;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (!resetn) begin
            counting   <= 1'b0;
            prev_start <= 1'b0;
        end else begin
            prev_start <= eng_start;
            if (eng_start) begin
                start_cnt <= start_cnt + 1;
                if (prev_start) dbl_start <= dbl_start + 1;
                counting <= 1'b1;
                wc       <= 0;
            end else if (counting) begin
                if (rsp_valid) begin
                    counting  <= 1'b0;
                    last_wait <= wc;
                end else begin
                    wc <= wc + 1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        req_opa[id*W +: W] = a;
        req_opb[id*W +: W] = b;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"},  req_ready,  0);
        check({tag, "_rsp_valid"},  rsp_valid,  0);
        check({tag, "_rsp_id"},     rsp_id,     0);
        check({tag, "_rsp_result"}, rsp_result, 0);
        check({tag, "_rsp_cycles"}, rsp_cycles, 0);
        check({tag, "_eng_opa"},    eng_opa,    0);
        check({tag, "_eng_opb"},    eng_opb,    0);
        check({tag, "_eng_start"},  eng_start,  0);
    endtask

    task automatic wait_grant(input string tag);
        int n;
        n = 0;
        while (req_ready == '0 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_grant_seen"}, (req_ready != '0), 1);
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_rsp_seen"}, rsp_valid, 1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic do_job(input string tag, input int id, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input bit byp);
        int s0;
        s0 = start_cnt;
        tick();
        set_ops(id, a, b);
        req_valid = NREQ'(1) << id;
        #1;
        check({tag, "_ready"}, req_ready, 64'(NREQ'(1) << id));
        tick();
        req_valid = '0;
        if (byp) check({tag, "_next_cycle"}, rsp_valid, 1);
        wait_rsp(tag);
        check({tag, "_id"},     rsp_id,     id);
        check({tag, "_result"}, rsp_result, exp);
        if (byp) begin
            check({tag, "_cycles"}, rsp_cycles, 0);
            check({tag, "_starts"}, start_cnt - s0, 0);
        end else begin
            check({tag, "_cycles"},  rsp_cycles, last_wait);
            check({tag, "_cyc_pos"}, (rsp_cycles != 0), 1);
            check({tag, "_starts"},  start_cnt - s0, 1);
            check({tag, "_opa"},     eng_opa, a);
        end
        ack();
        check({tag, "_drop"}, rsp_valid, 0);
    endtask

    logic [W-1:0] fair_a [4] = '{32'd12, 32'd35, 32'd81, 32'd17};
    logic [W-1:0] fair_b [4] = '{32'd8,  32'd14, 32'd27, 32'd5};
    logic [W-1:0] fair_r [4] = '{32'd4,  32'd7,  32'd27, 32'd1};

    initial begin
        resetn    = 1'b0;
        req_valid = '0;
        req_opa   = '0;
        req_opb   = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        resetn = 1'b1;

        do_job("single", 0, 32'd48, 32'd18, 32'd6, 1'b0);

        // Fresh reset so the pointer starts at 0 for the rotation check.
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) set_ops(i, fair_a[i], fair_b[i]);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            wait_grant("fair");
            check($sformatf("fair_grant%0d", k), req_ready, 64'(4'b0001 << (k % 4)));
            if (k == 4) begin
                tick();
                req_valid = '0;
            end
            wait_rsp("fair");
            check($sformatf("fair_id%0d", k),  rsp_id,     k % 4);
            check($sformatf("fair_res%0d", k), rsp_result, fair_r[k % 4]);
            tick();
        end
        rsp_ready = 1'b0;

        do_job("byp_0_7",  1, 32'd0,  32'd7, 32'd7,  1'b1);
        do_job("byp_13_0", 2, 32'd13, 32'd0, 32'd13, 1'b1);
        do_job("byp_0_0",  3, 32'd0,  32'd0, 32'd0,  1'b1);

        // Backpressure: hold the (100,75) response while requester 2 waits.
        tick();
        set_ops(1, 32'd100, 32'd75);
        req_valid = 4'b0010;
        #1;
        check("bp_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        wait_rsp("bp");
        set_ops(2, 32'd0, 32'd5);
        req_valid = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_hold_valid",  rsp_valid,  1);
            check("bp_hold_result", rsp_result, 25);
            check("bp_hold_noacc",  req_ready,  0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_same_cycle_noacc", req_ready, 0);
        tick();
        rsp_ready = 1'b0;
        check("bp_after_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        check("bp_next_valid",  rsp_valid,  1);
        check("bp_next_id",     rsp_id,     2);
        check("bp_next_result", rsp_result, 5);
        ack();

        // Reset in the middle of an engine job.
        tick();
        set_ops(2, 32'd1071, 32'd462);
        req_valid = 4'b0100;
        #1;
        check("rst_job_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        repeat (3) tick();
        check("rst_job_busy", rsp_valid, 0);
        #2;
        resetn = 1'b0;
        #1;
        check_zero("rst_mid");
        tick();
        resetn = 1'b1;
        set_ops(0, 32'd1071, 32'd462);
        set_ops(3, 32'd0, 32'd9);
        req_valid = 4'b1001;
        #1;
        check("rst_ptr0", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_rsp("rst_new");
        check("rst_new_id",     rsp_id,     0);
        check("rst_new_result", rsp_result, 21);
        check("rst_new_cycles", rsp_cycles, last_wait);
        ack();

        check("start_never_double", dbl_start, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
